// File: rtl/irrigation_valve_sequencer.sv
// Irrigation valve sequencer: qualify a request, open one valve, hold it, cool down.
// Define IRRIGATION_VALVE_TIMEOUT_EN to enable the MAX_ON_CYCLES limit and timeout pulse.
module irrigation_valve_sequencer #(
    parameter int STABLE_CYCLES   = 4,
    parameter int MIN_ON_CYCLES   = 10,
    parameter int MAX_ON_CYCLES   = 50,
    parameter int COOLDOWN_CYCLES = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       irrigation,
    input  logic       use_sprinkler,
    input  logic       emergency_stop,
    output logic       dripper_valve,
    output logic       sprinkler_valve,
    output logic       busy,
    output logic       timeout,
    output logic [1:0] state
);
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        QUALIFY  = 2'b01,
        OPEN     = 2'b10,
        COOLDOWN = 2'b11
    } state_t;

    localparam logic [15:0] STABLE_C = 16'(STABLE_CYCLES);
    localparam logic [15:0] MIN_C    = 16'(MIN_ON_CYCLES);
    localparam logic [15:0] COOL_C   = 16'(COOLDOWN_CYCLES);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, cnt_inc;
    logic        mode_q, mode_d;
    logic        drip_q, spr_q, timeout_q, timeout_d;
    logic        max_hit;

    // Counter holds the number of cycles spent in the current state, entry cycle included.
    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

`ifdef IRRIGATION_VALVE_TIMEOUT_EN
    localparam logic [15:0] MAX_C = 16'(MAX_ON_CYCLES);
    assign max_hit = (cnt_q >= MAX_C);
`else
    assign max_hit = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            mode_q    <= 1'b0;
            drip_q    <= 1'b0;
            spr_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            drip_q    <= (state_d == OPEN) && !mode_d;
            spr_q     <= (state_d == OPEN) && mode_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_inc;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                if (irrigation && !emergency_stop) begin
                    cnt_d = 16'd1;
                    if (STABLE_C <= 16'd1) state_d = OPEN;
                    else                   state_d = QUALIFY;
                end
            end
            QUALIFY: begin
                if (!irrigation || emergency_stop) begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                end else if (cnt_inc >= STABLE_C) begin
                    state_d = OPEN;
                    cnt_d   = 16'd1;
                end
            end
            OPEN: begin
                // Emergency wins over a coincident max-on expiry, so no timeout pulse then.
                if (emergency_stop) begin
                    state_d = COOLDOWN;
                    cnt_d   = 16'd1;
                end else if (max_hit) begin
                    state_d   = COOLDOWN;
                    cnt_d     = 16'd1;
                    timeout_d = 1'b1;
                end else if (!irrigation && cnt_q >= MIN_C) begin
                    state_d = COOLDOWN;
                    cnt_d   = 16'd1;
                end
            end
            COOLDOWN: begin
                if (cnt_q >= COOL_C) begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    always_comb begin
        mode_d          = mode_q;
        if (state_d == OPEN && state_q != OPEN) mode_d = use_sprinkler;
        busy            = (state_q != IDLE);
        state           = state_q;
        dripper_valve   = drip_q;
        sprinkler_valve = spr_q;
        timeout         = timeout_q;
    end
endmodule

// File: tb/tb_irrigation_valve_sequencer.sv
// Directed bench for irrigation_valve_sequencer: vector table plus multi-cycle sequences.
module tb_irrigation_valve_sequencer;
    logic       clock, reset;
    logic       irrigation, use_sprinkler, emergency_stop;
    logic       dripper_valve, sprinkler_valve, busy, timeout;
    logic [1:0] state;
    logic       irr2, spr2, estop2;
    logic       drip2, sprk2, busy2, to2;
    logic [1:0] state2;

    int checks = 0;
    int errors = 0;

    irrigation_valve_sequencer dut (
        .clock(clock), .reset(reset), .irrigation(irrigation),
        .use_sprinkler(use_sprinkler), .emergency_stop(emergency_stop),
        .dripper_valve(dripper_valve), .sprinkler_valve(sprinkler_valve),
        .busy(busy), .timeout(timeout), .state(state)
    );

    irrigation_valve_sequencer #(
        .STABLE_CYCLES(1), .MIN_ON_CYCLES(2), .MAX_ON_CYCLES(3), .COOLDOWN_CYCLES(1)
    ) u_fast (
        .clock(clock), .reset(reset), .irrigation(irr2),
        .use_sprinkler(spr2), .emergency_stop(estop2),
        .dripper_valve(drip2), .sprinkler_valve(sprk2),
        .busy(busy2), .timeout(to2), .state(state2)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (state !== 2'b00 && n < bound) begin
            step();
            n++;
        end
        chk("wait_idle", {30'd0, state}, 32'd0);
    endtask

    // Valves must never both be open, on either instance.
    always @(negedge clock) begin
        if (!reset) begin
            chk("exclusive", {30'd0, dripper_valve, sprinkler_valve} == 2'b11, 32'd0);
            chk("exclusive_fast", {30'd0, drip2, sprk2} == 2'b11, 32'd0);
        end
    end

    typedef struct {
        logic       irr, spr, estop;
        logic [1:0] st;
        logic       drip, sprk, bsy, to;
    } vec_t;

    vec_t tbl [23];

    initial begin
        int open_cnt, cool_cnt, q_edges, spr_cnt, drip_seen, to_cnt;

        // irr spr estop | state drip sprk busy timeout
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[19] = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[20] = '{1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[21] = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[22] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};

        reset = 1'b0;
        irrigation = 1'b0; use_sprinkler = 1'b0; emergency_stop = 1'b0;
        irr2 = 1'b0; spr2 = 1'b0; estop2 = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_outs", {28'd0, dripper_valve, sprinkler_valve, busy, timeout}, 32'd0);
        step();
        step();
        reset = 1'b0;
        chk("rst_hold", {30'd0, state}, 32'd0);

        // Vector table: qualification, estop at open cycle 2, cooldown, aborted qualifications
        for (int i = 0; i < 23; i++) begin
            irrigation = tbl[i].irr; use_sprinkler = tbl[i].spr; emergency_stop = tbl[i].estop;
            step();
            chk($sformatf("v%0d_state", i), {30'd0, state}, {30'd0, tbl[i].st});
            chk($sformatf("v%0d_drip", i), {31'd0, dripper_valve}, {31'd0, tbl[i].drip});
            chk($sformatf("v%0d_sprk", i), {31'd0, sprinkler_valve}, {31'd0, tbl[i].sprk});
            chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].bsy});
            chk($sformatf("v%0d_to", i), {31'd0, timeout}, {31'd0, tbl[i].to});
        end

        // Minimum on-time, cooldown length, fresh qualification afterwards
        irrigation = 1'b1; use_sprinkler = 1'b0; emergency_stop = 1'b0;
        repeat (4) step();
        chk("a_open", {30'd0, state}, 32'd2);
        chk("a_drip", {31'd0, dripper_valve}, 32'd1);
        open_cnt = 1;
        for (int k = 0; k < 30; k++) begin
            irrigation = (open_cnt < 3);
            step();
            if (dripper_valve) open_cnt++;
            else break;
        end
        chk("a_open_len", open_cnt, 32'd10);
        chk("a_cool_state", {30'd0, state}, 32'd3);
        chk("a_no_to", {31'd0, timeout}, 32'd0);
        irrigation = 1'b1;
        cool_cnt = 1;
        for (int k = 0; k < 30; k++) begin
            step();
            if (state == 2'b11 && !dripper_valve && !sprinkler_valve) cool_cnt++;
            else break;
        end
        chk("a_cool_len", cool_cnt, 32'd8);
        chk("a_idle", {30'd0, state}, 32'd0);
        q_edges = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            q_edges++;
            if (state == 2'b10) break;
        end
        chk("a_requal", q_edges, 32'd4);
        chk("a_drip2", {31'd0, dripper_valve}, 32'd1);
        emergency_stop = 1'b1;
        step();
        chk("a_estop_close", {30'd0, dripper_valve, sprinkler_valve}, 32'd0);
        wait_idle(30);
        emergency_stop = 1'b0;

        // Sprinkler with mode toggle, maximum on-time
        irrigation = 1'b1; use_sprinkler = 1'b1;
        repeat (4) step();
        chk("b_sprk", {30'd0, dripper_valve, sprinkler_valve}, 32'd1);
        spr_cnt = 1; drip_seen = 0; to_cnt = 0;
        for (int i = 0; i < 120; i++) begin
            if (i == 5) use_sprinkler = 1'b0;
            step();
            if (dripper_valve) drip_seen++;
            if (timeout) to_cnt++;
            if (sprinkler_valve) spr_cnt++;
            if (state != 2'b10) break;
        end
        chk("b_drip_never", drip_seen, 32'd0);
`ifdef IRRIGATION_VALVE_TIMEOUT_EN
        chk("b_on_len", spr_cnt, 32'd50);
        chk("b_to_count", to_cnt, 32'd1);
        chk("b_to_now", {31'd0, timeout}, 32'd1);
        irrigation = 1'b0;
        step();
        chk("b_to_pulse", {31'd0, timeout}, 32'd0);
        wait_idle(30);
`else
        chk("b_on_len", spr_cnt, 32'd121);
        chk("b_still_open", {30'd0, state}, 32'd2);
        chk("b_to_count", to_cnt, 32'd0);
        emergency_stop = 1'b1;
        step();
        chk("b_estop_state", {30'd0, state}, 32'd3);
        chk("b_estop_valves", {30'd0, dripper_valve, sprinkler_valve}, 32'd0);
        emergency_stop = 1'b0; irrigation = 1'b0;
        wait_idle(30);
`endif

        // Async reset mid-OPEN, then full requalification
        irrigation = 1'b1; use_sprinkler = 1'b0;
        repeat (5) step();
        chk("c_open", {31'd0, dripper_valve}, 32'd1);
        #3 reset = 1'b1;
        #1;
        chk("c_rst_outs", {28'd0, dripper_valve, sprinkler_valve, busy, timeout}, 32'd0);
        chk("c_rst_state", {30'd0, state}, 32'd0);
        #1 reset = 1'b0;
        q_edges = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            q_edges++;
            if (state == 2'b10) break;
        end
        chk("c_requal", q_edges, 32'd4);
        irrigation = 1'b0; emergency_stop = 1'b1;
        step();
        wait_idle(30);
        emergency_stop = 1'b0;

        // STABLE_CYCLES=1: IDLE goes straight to OPEN
        irr2 = 1'b1;
        step();
        chk("d_open", {30'd0, state2}, 32'd2);
        chk("d_drip", {31'd0, drip2}, 32'd1);
        irr2 = 1'b0;
        step();
        chk("d_min_hold", {31'd0, drip2}, 32'd1);
        step();
        chk("d_close", {30'd0, state2}, 32'd3);
        chk("d_close_valve", {31'd0, drip2}, 32'd0);
        step();
        chk("d_idle", {30'd0, state2}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
